uart_tx_buffered: RTL

- Buffered 8N1 UART transmitter: queues bytes in an internal FIFO, serialises them LSB-first on tx, and pulses tx_done at the end of each frame.
- Transmit-side counterpart to the receive path (uart_rx with its fifo_inst). Sits inside each uart side (uartA/uartB) of the full-duplex DUT as uart_tx_inst.
- Drives tx_A/tx_B and tx_done_A/tx_done_B. Its internal FIFO is named fifo_inst so the bench can probe it hierarchically.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 81 ++++++++
 rtl/uart_tx_buffered.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit/receive paths.
//   tx_state_e  : transmitter frame states
//   DATA_BITS   : payload bits per frame (8N1)
//   STOP_LEVEL  : line level for idle and stop bit
//   START_LEVEL : line level for the start bit
//   cnt_width() : bits needed to hold a counter that runs 0..max_val
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Never returns less than one bit, so degenerate counters still get a
    // legal vector width.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock first-word-fall-through FIFO, shared by the UART RX and TX paths.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset (clears pointers and count)
//   wr_en    : push request; ignored while full
//   data_in  : word to push
//   rd_en    : pop request; ignored while empty
//   data_out : head word, valid combinationally whenever empty=0
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : current occupancy
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A full FIFO refuses the write even when a pop happens in the same cycle.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    assign data_out = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered 8N1 UART transmitter. Bytes are queued in fifo_inst and sent
// LSB-first; consecutive queued bytes go out with no idle gap.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset; abandons any frame in flight
//   tx_start   : push strobe, data_in queued on every high cycle
//   data_in    : byte to queue
//   tx         : registered serial output, idles high
//   tx_done    : one-cycle pulse on the last cycle of each stop bit
//   busy       : a frame is in progress
//   fifo_full  : FIFO holds FIFO_DEPTH bytes
//   fifo_empty : FIFO holds no bytes
//   fifo_count : FIFO occupancy
//   overflow   : one-cycle pulse after a push was dropped on a full FIFO
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tx_start,
    input  logic [7:0]                      data_in,
    output logic                            tx,
    output logic                            tx_done,
    output logic                            busy,
    output logic                            fifo_full,
    output logic                            fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow
);

    localparam int             BW        = cnt_width(CLKS_PER_BIT - 1);
    localparam int             BITW      = cnt_width(DATA_BITS - 1);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(DATA_BITS - 1);

    tx_state_e              state_reg, state_next;
    logic [BW-1:0]          baud_reg, baud_next;
    logic [BITW-1:0]        bit_reg, bit_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   tx_reg, tx_next;
    logic                   done_reg, done_next;
    logic                   ovf_reg;
    logic                   fifo_rd;
    logic [DATA_BITS-1:0]   fifo_head;
    logic                   baud_last;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) fifo_inst (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (tx_start),
        .data_in  (data_in),
        .rd_en    (fifo_rd),
        .data_out (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign baud_last = (baud_reg == BAUD_LAST);

    // tx is computed for the next cycle and registered, so the line level
    // changes on the same edge as the state and never glitches.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        fifo_rd    = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = STOP_LEVEL;
                if (!fifo_empty) begin
                    fifo_rd    = 1'b1;
                    shift_next = fifo_head;
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                    tx_next    = START_LEVEL;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_reg == BIT_LAST) begin
                        state_next = STOP;
                        tx_next    = STOP_LEVEL;
                    end else begin
                        bit_next = bit_reg + BITW'(1);
                        tx_next  = shift_reg[bit_next];
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end

            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when more data
                    // is waiting; otherwise rest in IDLE.
                    if (!fifo_empty) begin
                        fifo_rd    = 1'b1;
                        shift_next = fifo_head;
                        bit_next   = '0;
                        state_next = START;
                        tx_next    = START_LEVEL;
                    end else begin
                        state_next = IDLE;
                        tx_next    = STOP_LEVEL;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = STOP_LEVEL;
            end
        endcase
    end

    // Registered pulse that lines up with the final cycle of the stop bit.
    assign done_next = (state_next == STOP) && (baud_next == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= STOP_LEVEL;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            done_reg  <= done_next;
            ovf_reg   <= tx_start && fifo_full;
        end
    end

    assign tx       = tx_reg;
    assign tx_done  = done_reg;
    assign busy     = (state_reg != IDLE);
    assign overflow = ovf_reg;

endmodule
